// File: rtl/pattern_stim_if.sv
// Control and pattern bus between a stimulus consumer and pattern_stim_gen.
interface pattern_stim_if;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       busy;
  logic       step_strobe;
  logic       done;

  modport master (
    output start, stop, mode,
    input  A, B, C, D, busy, step_strobe, done
  );

  modport slave (
    input  start, stop, mode,
    output A, B, C, D, busy, step_strobe, done
  );
endinterface

// File: rtl/pattern_stim_gen.sv
// 4-bit stimulus source: steps binary, Gray or walking-one patterns at a
// clock-divided rate for a fixed number of sweeps, then pulses done.
module pattern_stim_gen #(
  parameter int unsigned TICK_DIV = 5,
  parameter int unsigned SWEEPS   = 1
) (
  input logic           clk,
  input logic           rst_n,
  pattern_stim_if.slave bus
);

  localparam int unsigned PW = $clog2(TICK_DIV) + 1;
  localparam int unsigned SW = $clog2(SWEEPS) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      idx_q, idx_d;
  logic [SW-1:0]   sweep_q, sweep_d;
  logic [1:0]      mode_q, mode_d;
  logic [3:0]      pat_q, pat_d;
  logic            busy_q, busy_d;
  logic            strobe_q, strobe_d;
  logic            done_q, done_d;
  logic [3:0]      idx_last_c;

  // Index-to-pattern mapping; mode 11 falls back to binary
  function automatic logic [3:0] map_pat(input logic [1:0] m, input logic [3:0] i);
    logic [3:0] p;
    case (m)
      2'b01:   p = i ^ (i >> 1);
      2'b10:   p = 4'b1000 >> i[1:0];
      default: p = i;
    endcase
    return p;
  endfunction

  assign idx_last_c = (mode_q == 2'b10) ? 4'd3 : 4'd15;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      idx_q    <= '0;
      sweep_q  <= '0;
      mode_q   <= '0;
      pat_q    <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      sweep_q  <= sweep_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    idx_d    = idx_q;
    sweep_d  = sweep_q;
    mode_d   = mode_q;
    pat_d    = '0;
    busy_d   = 1'b0;
    strobe_d = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = S_RUN;
          mode_d  = bus.mode;
          presc_d = '0;
          idx_d   = '0;
          sweep_d = '0;
          pat_d   = map_pat(bus.mode, 4'd0);
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        pat_d  = pat_q;
        if (bus.stop) begin
          // Abort wins over any coincident terminal count
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pat_d   = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (idx_q == idx_last_c) begin
            if (sweep_q == SWEEP_LAST) begin
              state_d = S_DONE;
              busy_d  = 1'b0;
              pat_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d    = '0;
              sweep_d  = sweep_q + SW'(1);
              pat_d    = map_pat(mode_q, 4'd0);
              strobe_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 4'd1;
            pat_d    = map_pat(mode_q, idx_q + 4'd1);
            strobe_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.A           = pat_q[3];
  assign bus.B           = pat_q[2];
  assign bus.C           = pat_q[1];
  assign bus.D           = pat_q[0];
  assign bus.busy        = busy_q;
  assign bus.step_strobe = strobe_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_pattern_stim_gen.sv
// Scoreboard bench for pattern_stim_gen: three parameterisations, expected
// events (run start, steps, done, abort) queued by the driver, checked by monitors.
`timescale 1ns/100ps
module tb_pattern_stim_gen;

  localparam int K_START = 0;
  localparam int K_STEP  = 1;
  localparam int K_DONE  = 2;
  localparam int K_STOP  = 3;

  typedef struct {
    int         kind;
    int         stamp;
    logic [3:0] pat;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_v [3];
  logic       stop_v  [3];
  logic [1:0] mode_v  [3];
  logic [3:0] obs_pat [3];
  logic       obs_busy[3];
  logic       obs_strb[3];
  logic       obs_done[3];

  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  ev_t exp_q[3][$];

  pattern_stim_if bus0 ();
  pattern_stim_if bus1 ();
  pattern_stim_if bus2 ();

  pattern_stim_gen #(.TICK_DIV(5), .SWEEPS(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  pattern_stim_gen #(.TICK_DIV(2), .SWEEPS(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  pattern_stim_gen #(.TICK_DIV(1), .SWEEPS(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  assign bus0.start = start_v[0];
  assign bus0.stop  = stop_v[0];
  assign bus0.mode  = mode_v[0];
  assign bus1.start = start_v[1];
  assign bus1.stop  = stop_v[1];
  assign bus1.mode  = mode_v[1];
  assign bus2.start = start_v[2];
  assign bus2.stop  = stop_v[2];
  assign bus2.mode  = mode_v[2];

  assign obs_pat[0]  = {bus0.A, bus0.B, bus0.C, bus0.D};
  assign obs_busy[0] = bus0.busy;
  assign obs_strb[0] = bus0.step_strobe;
  assign obs_done[0] = bus0.done;
  assign obs_pat[1]  = {bus1.A, bus1.B, bus1.C, bus1.D};
  assign obs_busy[1] = bus1.busy;
  assign obs_strb[1] = bus1.step_strobe;
  assign obs_done[1] = bus1.done;
  assign obs_pat[2]  = {bus2.A, bus2.B, bus2.C, bus2.D};
  assign obs_busy[2] = bus2.busy;
  assign obs_strb[2] = bus2.step_strobe;
  assign obs_done[2] = bus2.done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int td_of(input int g);
    return (g == 0) ? 5 : (g == 1) ? 2 : 1;
  endfunction

  function automatic int sw_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 3;
  endfunction

  function automatic int len_of(input logic [1:0] m);
    return (m == 2'd2) ? 4 : 16;
  endfunction

  // Reference pattern for step k of a sequence
  function automatic logic [3:0] ref_pat(input logic [1:0] m, input int k);
    int v;
    if (m == 2'd2)      v = 8 >> k;
    else if (m == 2'd1) v = k ^ (k / 2);
    else                v = k;
    return 4'(v);
  endfunction

  task automatic check(input bit ok, input string what, input int g, input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s dut%0d @cyc %0d: got %0h, required %0h", what, g, cyc, act, req);
    end
  endtask

  task automatic push_ev(input int g, input int kind, input int stamp, input logic [3:0] pat);
    ev_t e;
    e.kind  = kind;
    e.stamp = stamp;
    e.pat   = pat;
    exp_q[g].push_back(e);
  endtask

  // Monitors: classify each output event and compare against the queue head
  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin : mon
      logic       pb;
      logic [3:0] pp;
      logic [3:0] pat;
      int         kind;
      ev_t        e;
      pb = 1'b0;
      pp = 4'd0;
      forever begin
        @(negedge clk);
        pat = obs_pat[g];
        if (rst_n === 1'b1) begin
          kind = -1;
          if (obs_done[g])                  kind = K_DONE;
          else if (obs_strb[g])             kind = K_STEP;
          else if (obs_busy[g] && !pb)      kind = K_START;
          else if (!obs_busy[g] && pb)      kind = K_STOP;
          if (kind >= 0) begin
            n_tests++;
            if (exp_q[g].size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_event dut%0d @cyc %0d: got kind %0d pat %b, required none",
                       g, cyc, kind, pat);
            end else begin
              e = exp_q[g].pop_front();
              if (kind != e.kind || cyc != e.stamp || pat != e.pat) begin
                n_fail++;
                $display("FAIL event dut%0d: got kind %0d cyc %0d pat %b, required kind %0d cyc %0d pat %b",
                         g, kind, cyc, pat, e.kind, e.stamp, e.pat);
              end
            end
          end
          if (!obs_busy[g]) check(pat == 4'd0, "idle_pattern_zero", g, int'(pat), 0);
          else if (pb && !obs_strb[g]) check(pat == pp, "pattern_hold", g, int'(pat), int'(pp));
        end
        pb = obs_busy[g];
        pp = pat;
      end
    end
  end

  // One run: stop_off>0 aborts at that edge offset, junk_off>0 pulses start and
  // rewrites mode mid-run, rst_off>=0 pulses reset between edges
  task automatic do_run(input int g, input logic [1:0] m, input int stop_off,
                        input int junk_off, input logic [1:0] junk_mode, input int rst_off);
    int t0, len, n, td, st, guard;
    @(negedge clk);
    mode_v[g]  = m;
    start_v[g] = 1'b1;
    t0  = cyc + 1;
    td  = td_of(g);
    len = len_of(m);
    n   = len * sw_of(g);
    push_ev(g, K_START, t0, ref_pat(m, 0));
    for (int k = 1; k < n; k++) begin
      st = t0 + k * td;
      if (stop_off > 0 && st >= t0 + stop_off) break;
      push_ev(g, K_STEP, st, ref_pat(m, k % len));
    end
    if (stop_off > 0) push_ev(g, K_STOP, t0 + stop_off, 4'd0);
    else              push_ev(g, K_DONE, t0 + n * td, 4'd0);

    guard = 0;
    while (exp_q[g].size() != 0 && guard < n * td + 20) begin
      @(negedge clk);
      guard++;
      start_v[g] = 1'b0;
      stop_v[g]  = 1'b0;
      if (stop_off > 0 && cyc + 1 == t0 + stop_off) stop_v[g] = 1'b1;
      if (junk_off > 0 && cyc == t0 + junk_off) begin
        start_v[g] = 1'b1;
        mode_v[g]  = junk_mode;
      end
      if (rst_off >= 0 && cyc == t0 + rst_off) begin
        #1 rst_n = 1'b0;
        #0.5;
        check({obs_pat[g], obs_busy[g], obs_strb[g], obs_done[g]} == 7'd0,
              "async_reset_clear", g,
              int'({obs_pat[g], obs_busy[g], obs_strb[g], obs_done[g]}), 0);
        exp_q[g].delete();
        push_ev(g, K_STOP, cyc + 1, 4'd0);
        #0.5 rst_n = 1'b1;
      end
    end
    if (exp_q[g].size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout dut%0d: %0d events still pending, required 0", g, exp_q[g].size());
      exp_q[g].delete();
    end
    @(negedge clk);
    start_v[g] = 1'b0;
    stop_v[g]  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int g, dur, stop_off, junk_off, rst_off, r;
    logic [1:0] m;

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b1;
      stop_v[i]  = 1'b0;
      mode_v[i]  = 2'b00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check({obs_pat[i], obs_busy[i], obs_strb[i], obs_done[i]} == 7'd0, "reset_state", i,
            int'({obs_pat[i], obs_busy[i], obs_strb[i], obs_done[i]}), 0);
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) check(obs_busy[i] == 1'b0, "idle_after_reset", i, int'(obs_busy[i]), 0);

    do_run(0, 2'b00, 0, 40, 2'b01, -1);   // binary, ignored restart + mode change
    do_run(1, 2'b01, 0, 0, 2'b00, -1);    // Gray, two sweeps
    do_run(0, 2'b10, 0, 7, 2'b00, -1);    // walking-one, mode forced to 00 mid-run
    do_run(0, 2'b00, 32, 12, 2'b11, -1);  // abort while 0110 is shown
    do_run(1, 2'b00, 0, 0, 2'b00, 21);    // asynchronous reset mid-run
    do_run(1, 2'b00, 0, 0, 2'b00, -1);    // clean restart after reset
    do_run(2, 2'b11, 0, 0, 2'b00, -1);    // mode 11, strobe every cycle
    do_run(1, 2'b01, 64, 0, 2'b00, -1);   // abort on the final terminal count

    // start and stop together in IDLE must not start a run
    @(negedge clk);
    start_v[0] = 1'b1;
    stop_v[0]  = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    stop_v[0]  = 1'b0;
    check(obs_busy[0] == 1'b0, "start_with_stop", 0, int'(obs_busy[0]), 0);
    repeat (3) @(negedge clk);

    for (int it = 0; it < 16; it++) begin
      g   = int'($urandom_range(0, 2));
      m   = 2'($urandom_range(0, 3));
      dur = len_of(m) * sw_of(g) * td_of(g);
      r   = int'($urandom_range(0, 5));
      stop_off = 0;
      junk_off = 0;
      rst_off  = -1;
      if (r == 0) begin
        rst_off = int'($urandom_range(0, dur - 1));
      end else if (r <= 2) begin
        stop_off = int'($urandom_range(1, dur));
        if (stop_off >= 3) junk_off = int'($urandom_range(1, stop_off - 2));
      end else begin
        junk_off = int'($urandom_range(1, dur));
      end
      do_run(g, m, stop_off, junk_off, 2'($urandom_range(0, 3)), rst_off);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
